// File: rtl/apb_rr_cmd_bridge_pkg.sv
// Shared types and helpers for the multi-requester APB command bridge.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_t;

    // Port index width; a single-port build still needs one bit.
    function automatic int port_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_cmd_bridge_if.sv
// Requester, APB and response signal bundle for apb_rr_cmd_bridge.
interface apb_rr_cmd_bridge_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    import apb_bridge_pkg::*;

    localparam int PORT_W = port_bits(NUM_PORTS);

    logic [NUM_PORTS-1:0]        req_valid_i;
    logic [NUM_PORTS-1:0]        req_write_i;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr_i;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata_i;
    logic [NUM_PORTS-1:0]        req_gnt_o;

    logic                        psel_o;
    logic                        penable_o;
    logic                        pwrite_o;
    logic [ADDR_W-1:0]           paddr_o;
    logic [DATA_W-1:0]           pwdata_o;
    logic                        pready_i;
    logic [DATA_W-1:0]           prdata_i;
    logic                        pslverr_i;

    logic                        rsp_valid_o;
    logic [PORT_W-1:0]           rsp_port_o;
    logic                        rsp_write_o;
    logic [DATA_W-1:0]           rsp_data_o;
    logic                        rsp_err_o;
    logic                        fifo_full_o;
    logic                        fifo_empty_o;

    // Bridge side: APB master towards the slave, acceptor towards requesters.
    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output req_gnt_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  pready_i, prdata_i, pslverr_i,
        output rsp_valid_o, rsp_port_o, rsp_write_o, rsp_data_o, rsp_err_o,
        output fifo_full_o, fifo_empty_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  req_gnt_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output pready_i, prdata_i, pslverr_i,
        input  rsp_valid_o, rsp_port_o, rsp_write_o, rsp_data_o, rsp_err_o,
        input  fifo_full_o, fifo_empty_o
    );

endinterface

// File: rtl/apb_rr_cmd_bridge_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is visible combinationally on rdata.
module apb_bridge_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/apb_rr_cmd_bridge.sv
// N-port round-robin arbiter feeding a command FIFO, drained by an APB master
// FSM that returns one tagged response per completed transfer.
module apb_rr_cmd_bridge #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 15
) (
    input logic               clk,
    input logic               reset_n,
    apb_rr_cmd_bridge_if.master bus
);
    import apb_bridge_pkg::*;

    localparam int PORT_W = port_bits(NUM_PORTS);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_arr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_arr;
    assign addr_arr  = bus.req_addr_i;
    assign wdata_arr = bus.req_wdata_i;

    logic [PORT_W-1:0]    rr_ptr;
    logic [PORT_W:0]      sum;
    logic [NUM_PORTS-1:0] gnt;
    logic [PORT_W-1:0]    gnt_idx;
    logic                 gnt_any;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    cmd_t                 push_cmd;
    cmd_t                 head;

    // Search upward from rr_ptr with wrap; a full FIFO blocks every grant,
    // even in a cycle that also pops.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sum     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = {1'b0, rr_ptr} + (PORT_W+1)'(i);
            if (sum >= (PORT_W+1)'(NUM_PORTS))
                sum = sum - (PORT_W+1)'(NUM_PORTS);
            if (!gnt_any && !fifo_full && bus.req_valid_i[sum[PORT_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = sum[PORT_W-1:0];
            end
        end
        if (gnt_any)
            gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (gnt_any)
            rr_ptr <= (gnt_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PORT_W'(1);
    end

    assign push_cmd.port  = gnt_idx;
    assign push_cmd.write = bus.req_write_i[gnt_idx];
    assign push_cmd.addr  = addr_arr[gnt_idx];
    assign push_cmd.wdata = wdata_arr[gnt_idx];

    apb_bridge_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (gnt_any),
        .wdata   (push_cmd),
        .pop     (pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    apb_state_t        state;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [PORT_W-1:0] cmd_port;
    logic [WCNT_W-1:0] wcnt;
    logic              tmo;
    logic              done;
    logic              rsp_valid;
    logic [PORT_W-1:0] rsp_port;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // wcnt holds the number of ACCESS cycles already spent without pready.
    assign tmo  = (wcnt == WCNT_W'(TIMEOUT - 1)) && !bus.pready_i;
    assign done = (state == ST_ACCESS) && (bus.pready_i || tmo);
    assign pop  = !fifo_empty && ((state == ST_IDLE) || done);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            cmd_port  <= '0;
            wcnt      <= '0;
            rsp_valid <= 1'b0;
            rsp_port  <= '0;
            rsp_write <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (done) begin
                rsp_port  <= cmd_port;
                rsp_write <= pwrite;
                rsp_err   <= bus.pslverr_i || !bus.pready_i;
                rsp_data  <= (!pwrite && bus.pready_i && !bus.pslverr_i) ? bus.prdata_i : '0;
            end
            // A pop always loads the command register and enters SETUP.
            if (pop) begin
                state    <= ST_SETUP;
                psel     <= 1'b1;
                penable  <= 1'b0;
                pwrite   <= head.write;
                paddr    <= head.addr;
                pwdata   <= head.write ? head.wdata : '0;
                cmd_port <= head.port;
                wcnt     <= '0;
            end else begin
                case (state)
                    ST_SETUP: begin
                        state   <= ST_ACCESS;
                        penable <= 1'b1;
                    end
                    ST_ACCESS: begin
                        wcnt <= wcnt + WCNT_W'(1);
                        if (done) begin
                            state   <= ST_IDLE;
                            psel    <= 1'b0;
                            penable <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.req_gnt_o    = gnt;
    assign bus.psel_o       = psel;
    assign bus.penable_o    = penable;
    assign bus.pwrite_o     = pwrite;
    assign bus.paddr_o      = paddr;
    assign bus.pwdata_o     = pwdata;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_port_o   = rsp_port;
    assign bus.rsp_write_o  = rsp_write;
    assign bus.rsp_data_o   = rsp_data;
    assign bus.rsp_err_o    = rsp_err;
    assign bus.fifo_full_o  = fifo_full;
    assign bus.fifo_empty_o = fifo_empty;

endmodule

// File: tb/tb_apb_rr_cmd_bridge.sv
// Directed bench for apb_rr_cmd_bridge: vector table plus multi-cycle sequences.
module tb_apb_rr_cmd_bridge;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    apb_rr_cmd_bridge_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_rr_cmd_bridge #(
        .NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .DEPTH(8), .TIMEOUT(15)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    logic [3:0]        valid = '0;
    logic [3:0]        wr = '0;
    logic [3:0][31:0]  addr = '0;
    logic [3:0][31:0]  wdata = '0;
    logic              pready_r = 1'b0;
    logic [31:0]       prdata_r = '0;
    logic              perr_r = 1'b0;
    int                slv_waits = 0;
    int                acc_cnt = 0;

    assign bus.req_valid_i = valid;
    assign bus.req_write_i = wr;
    assign bus.req_addr_i  = addr;
    assign bus.req_wdata_i = wdata;
    assign bus.pready_i    = pready_r;
    assign bus.prdata_i    = prdata_r;
    assign bus.pslverr_i   = perr_r;

    // Slave: ready on ACCESS cycle index slv_waits (0-based); huge value = never.
    always @(negedge clk) begin
        if (bus.psel_o && bus.penable_o) begin
            pready_r = (acc_cnt == slv_waits);
            acc_cnt++;
        end else begin
            pready_r = 1'b0;
            acc_cnt  = 0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          acc;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          acc_run = 0, last_acc = 0, psel_rises = 0;
    int          psel_rise_cyc = 0, pen_rise_cyc = 0, stab_err = 0;
    logic        prev_psel = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic        s_wr = 1'b0;

    always @(negedge clk) begin
        if (bus.psel_o && !prev_psel) begin
            psel_rises++;
            psel_rise_cyc = cyc;
        end
        if (bus.psel_o && !bus.penable_o) begin
            s_addr  = bus.paddr_o;
            s_wdata = bus.pwdata_o;
            s_wr    = bus.pwrite_o;
        end
        if (bus.penable_o) begin
            if (acc_run == 0) pen_rise_cyc = cyc;
            acc_run++;
            if (bus.paddr_o !== s_addr || bus.pwdata_o !== s_wdata || bus.pwrite_o !== s_wr)
                stab_err++;
        end else if (acc_run != 0) begin
            last_acc = acc_run;
            acc_run  = 0;
        end
        prev_psel = bus.psel_o;
        if (bus.rsp_valid_o)
            rsp_q.push_back('{int'(bus.rsp_port_o), bus.rsp_write_o, bus.rsp_data_o,
                              bus.rsp_err_o, cyc, last_acc});
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        oh_idx = -1;
        for (int i = 0; i < 4; i++) if (v[i]) oh_idx = i;
    endfunction

    task automatic do_reset();
        valid = '0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rsp_q.delete();
        acc_run = 0;
    endtask

    task automatic do_req(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int tg);
        @(negedge clk);
        valid[p] = 1'b1; wr[p] = w; addr[p] = a; wdata[p] = d;
        #1;
        tg = -1;
        for (int k = 0; k < 200; k++) begin
            if (bus.req_gnt_o[p]) begin tg = cyc; break; end
            @(negedge clk); #1;
        end
        if (tg < 0) chk("grant_wait", 64'd0, 64'd1);
        @(posedge clk); #1;
        valid[p] = 1'b0;
    endtask

    task automatic get_rsp(output rsp_t r, output bit ok);
        ok = 1'b0;
        r  = '{default: 0};
        for (int k = 0; k < 100; k++) begin
            if (rsp_q.size() > 0) begin r = rsp_q.pop_front(); ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) chk("rsp_wait", 64'd0, 64'd1);
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] addr, wdata;
        int          waits;
        logic [31:0] prdata;
        logic        perr;
        logic [31:0] exp_pwdata, exp_data;
        logic        exp_err;
        int          exp_acc, exp_lat;
    } vec_t;

    vec_t vec[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rsp_t r, r0, r1;
        bit   ok, ok0, ok1;
        int   tg, tg2, rise0, stab0, n;
        int   gord[8];

        vec[0] = '{2, 1'b0, 32'h40,  32'h0,        0,    32'h12345678, 1'b0, 32'h0,        32'h12345678, 1'b0, 1,  4};
        vec[1] = '{0, 1'b1, 32'h8,   32'hDEADBEEF, 3,    32'h99999999, 1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 4,  7};
        vec[2] = '{1, 1'b0, 32'h100, 32'h77777777, 2,    32'h0000A5A5, 1'b1, 32'h0,        32'h0,        1'b1, 3,  6};
        vec[3] = '{3, 1'b1, 32'hFC,  32'h1,        1,    32'h55555555, 1'b0, 32'h1,        32'h0,        1'b0, 2,  5};
        vec[4] = '{3, 1'b0, 32'h20,  32'h0,        1,    32'hCAFEF00D, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0, 2,  5};
        vec[5] = '{1, 1'b0, 32'h44,  32'h0,        1000, 32'h13572468, 1'b0, 32'h0,        32'h0,        1'b1, 15, 18};

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_outs", {bus.req_gnt_o, bus.psel_o, bus.penable_o, bus.pwrite_o,
                           bus.rsp_valid_o, bus.rsp_write_o, bus.rsp_err_o, bus.fifo_full_o,
                           bus.rsp_port_o}, 64'd0);
        chk("reset_buses", {bus.paddr_o | bus.pwdata_o | bus.rsp_data_o}, 64'd0);
        chk("reset_empty", bus.fifo_empty_o, 64'd1);
        reset_n = 1'b1;

        // Single transfers from idle: data, error, wait states, timeout, latency
        for (int i = 0; i < 6; i++) begin
            slv_waits = vec[i].waits; prdata_r = vec[i].prdata; perr_r = vec[i].perr;
            stab0 = stab_err;
            do_req(vec[i].port, vec[i].wr, vec[i].addr, vec[i].wdata, tg);
            get_rsp(r, ok);
            if (ok) begin
                chk($sformatf("v%0d_port", i),  r.port, vec[i].port);
                chk($sformatf("v%0d_write", i), r.wr, vec[i].wr);
                chk($sformatf("v%0d_data", i),  r.data, vec[i].exp_data);
                chk($sformatf("v%0d_err", i),   r.err, vec[i].exp_err);
                chk($sformatf("v%0d_acc", i),   r.acc, vec[i].exp_acc);
                chk($sformatf("v%0d_lat", i),   r.cyc - tg, vec[i].exp_lat);
                chk($sformatf("v%0d_psel_t", i), psel_rise_cyc - tg, 2);
                chk($sformatf("v%0d_pen_t", i), pen_rise_cyc - tg, 3);
                chk($sformatf("v%0d_paddr", i), s_addr, vec[i].addr);
                chk($sformatf("v%0d_pwdata", i), s_wdata, vec[i].exp_pwdata);
                chk($sformatf("v%0d_stable", i), stab_err - stab0, 0);
            end
            repeat (3) @(negedge clk);
            #1;
            chk($sformatf("v%0d_one_pulse", i), rsp_q.size(), 0);
        end

        // All four ports requesting continuously from reset
        do_reset();
        slv_waits = 0; perr_r = 1'b0; prdata_r = 32'h0;
        rise0 = psel_rises;
        @(negedge clk);
        for (int p = 0; p < 4; p++) addr[p] = 32'h1000 + 32'(p * 4);
        wr = '0;
        valid = 4'hF;
        #1;
        n = 0;
        for (int k = 0; k < 100 && n < 8; k++) begin
            if (bus.req_gnt_o != 4'h0) begin gord[n] = oh_idx(bus.req_gnt_o); n++; end
            if (n < 8) begin @(negedge clk); #1; end
        end
        @(posedge clk); #1;
        valid = '0;
        chk("rr_count", n, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("rr_gnt%0d", i), gord[i], i % 4);
        for (int i = 0; i < 8; i++) begin
            get_rsp(r, ok);
            if (ok) chk($sformatf("rr_rsp%0d", i), r.port, i % 4);
        end
        chk("rr_psel_cont", psel_rises - rise0, 1);

        // FIFO fill under a stalled slave
        do_reset();
        slv_waits = 1000;
        @(negedge clk);
        valid[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h200; wdata[0] = 32'h11;
        #1;
        for (int k = 0; k < 50 && !bus.req_gnt_o[0]; k++) begin @(negedge clk); #1; end
        for (int k = 0; k <= 18; k++) begin
            chk($sformatf("full_gnt%0d", k), bus.req_gnt_o[0], (k <= 8 || k == 18));
            chk($sformatf("full_flag%0d", k), bus.fifo_full_o, (k >= 9 && k <= 17));
            @(negedge clk); #1;
        end
        valid = '0;

        // Two timeouts back to back
        do_reset();
        slv_waits = 1000; prdata_r = 32'hFFFF0000; perr_r = 1'b0;
        rise0 = psel_rises;
        do_req(0, 1'b0, 32'h300, 32'h0, tg);
        do_req(1, 1'b0, 32'h304, 32'h0, tg2);
        get_rsp(r0, ok0);
        get_rsp(r1, ok1);
        if (ok0 && ok1) begin
            chk("tmo_acc0", r0.acc, 15);
            chk("tmo_acc1", r1.acc, 15);
            chk("tmo_err", {r0.err, r1.err}, 2'b11);
            chk("tmo_data", r0.data | r1.data, 0);
            chk("tmo_lat", r0.cyc - tg, 18);
            chk("tmo_gap", r1.cyc - r0.cyc, 16);
            chk("tmo_port1", r1.port, 1);
        end
        chk("tmo_psel_cont", psel_rises - rise0, 1);

        // Reset mid-ACCESS with three queued commands
        do_reset();
        slv_waits = 1000;
        @(negedge clk);
        valid = 4'hF;
        #1;
        n = 0;
        for (int k = 0; k < 50 && n < 4; k++) begin
            if (bus.req_gnt_o != 4'h0) n++;
            if (n < 4) begin @(negedge clk); #1; end
        end
        @(posedge clk); #1;
        valid = '0;
        for (int k = 0; k < 50 && !bus.penable_o; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("rst_pre_empty", bus.fifo_empty_o, 0);
        rise0 = psel_rises;
        rsp_q.delete();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_psel", {bus.psel_o, bus.penable_o}, 2'b00);
        chk("rst_empty", bus.fifo_empty_o, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_after_empty", bus.fifo_empty_o, 1);
        repeat (25) @(negedge clk);
        #1;
        chk("rst_no_rsp", rsp_q.size(), 0);
        chk("rst_no_psel", psel_rises - rise0, 0);
        @(negedge clk);
        valid = 4'b0101;
        #1;
        chk("rst_next_gnt", bus.req_gnt_o, 4'b0001);
        @(posedge clk); #1;
        valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
